// File: rtl/onchip_mem_stream_loader.sv
// Framed byte-stream loader for the on-chip program RAM: parses a 4-byte header,
// packs little-endian words and writes them one per word, holding the CPU while busy.
module onchip_mem_stream_loader #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  output logic                  mem_clken,
  output logic                  mem_reset_req,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] H_ALO = 3'd0;
  localparam logic [2:0] H_AHI = 3'd1;
  localparam logic [2:0] H_LLO = 3'd2;
  localparam logic [2:0] H_LHI = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [2:0]            state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [7:0]            alo_q, alo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idle_q, idle_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  err_q, err_d;
  logic                  acc_s;
  logic                  idle_run_s;
  logic [15:0]           len_hdr_s;

  assign acc_s      = s_valid & s_ready;
  assign idle_run_s = (state_q != H_ALO) && (state_q != FIN);
  assign len_hdr_s  = {s_data, len_q[7:0]};

  // Next-state: header parsing, word assembly, write issue and idle timeout
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    alo_d   = alo_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    idle_d  = 16'd0;

    if (acc_s) begin
      case (state_q)
        H_ALO: begin
          alo_d   = s_data;
          state_d = H_AHI;
        end
        H_AHI: begin
          addr_d  = ADDR_WIDTH'({s_data, alo_q});
          state_d = H_LLO;
        end
        H_LLO: begin
          len_d   = {8'h00, s_data};
          state_d = H_LHI;
        end
        H_LHI: begin
          len_d   = len_hdr_s;
          bcnt_d  = 2'd0;
          state_d = (len_hdr_s == 16'd0) ? FIN : DATA;
        end
        DATA: begin
          bcnt_d  = bcnt_q + 2'd1;
          shift_d = {s_data, shift_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wr_d    = 1'b1;
            wdata_d = {s_data, shift_q};
            waddr_d = addr_q;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? FIN : DATA;
          end else begin
            wr_d = 1'b0;
          end
        end
        default: state_d = H_ALO;
      endcase
    end else if (state_q == FIN) begin
      state_d = H_ALO;
    end else if (idle_run_s) begin
      // An accepted byte always beats the timeout, hence this sits in the no-byte branch
      if ((TMO != 16'd0) && ((idle_q + 16'd1) == TMO)) begin
        state_d = H_ALO;
        bcnt_d  = 2'd0;
        err_d   = 1'b1;
        idle_d  = 16'd0;
      end else begin
        idle_d  = idle_q + 16'd1;
      end
    end else begin
      idle_d = 16'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= H_ALO;
      bcnt_q  <= 2'd0;
      shift_q <= 24'd0;
      alo_q   <= 8'd0;
      addr_q  <= '0;
      len_q   <= 16'd0;
      idle_q  <= 16'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      waddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      alo_q   <= alo_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

  assign s_ready        = (state_q != FIN);
  assign busy           = (state_q != H_ALO);
  assign done           = (state_q == FIN);
  assign mem_clken      = ~busy;
  assign mem_reset_req  = busy;
  assign mem_write      = wr_q;
  assign mem_chipselect = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_address    = waddr_q;
  assign mem_byteenable = 4'hF;
  assign error          = err_q;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Scoreboard bench for onchip_mem_stream_loader: frames are driven with random gaps,
// expected writes/done pulses are queued and checked by an independent monitor.
module tb_onchip_mem_stream_loader;
  localparam int AW  = 9;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0]   mem_writedata;
  logic          busy, done, error;

  onchip_mem_stream_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_reset_req(mem_reset_req), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic acc_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc_q <= s_valid && s_ready && reset_n;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            stamp;
  } wr_t;

  wr_t         exp_q[$];
  int          done_q[$];
  logic [31:0] words[$];
  logic [31:0] ref_ram [512];
  logic [31:0] dut_ram [512];
  int          n_chk = 0;
  int          n_fail = 0;
  int          err_cnt = 0;
  bit          done_prev = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present one byte after `gap` idle cycles; stamp = cycle in which its effects appear
  task automatic send_byte(input logic [7:0] b, input int gap, output int stamp);
    int w;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_data  = b;
    s_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 20) begin w++; @(negedge clk); end
    if (!s_ready) chk(1'b0, "ready_wait_expired", 32'(s_ready), 32'd1);
    stamp = cyc + 1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Reference model: header plus ndata bytes of `words`; completed words land at start+k mod 512
  task automatic frame(input int a16, input int len, input int ndata, input int gmax);
    int st, ad;
    logic [31:0] w;
    send_byte(a16[7:0],  $urandom_range(gmax, 0), st);
    send_byte(a16[15:8], $urandom_range(gmax, 0), st);
    send_byte(len[7:0],  $urandom_range(gmax, 0), st);
    send_byte(len[15:8], $urandom_range(gmax, 0), st);
    if (len == 0) done_q.push_back(st);
    for (int i = 0; i < ndata; i++) begin
      w = words[i/4];
      send_byte(w[8*(i%4) +: 8], $urandom_range(gmax, 0), st);
      if (i % 4 == 3) begin
        ad = ((a16 % 512) + i/4) % 512;
        exp_q.push_back('{addr: AW'(ad), data: w, stamp: st});
        ref_ram[ad] = w;
        if (i/4 == len - 1) done_q.push_back(st);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk(s_ready == 1'b1 && busy == 1'b0 && done == 1'b0 && error == 1'b0,
        {tag, "_ctrl"}, {28'd0, s_ready, busy, done, error}, 32'h8);
    chk(mem_write == 1'b0 && mem_chipselect == 1'b0 && mem_clken == 1'b1 && mem_reset_req == 1'b0,
        {tag, "_memctl"}, {28'd0, mem_write, mem_chipselect, mem_clken, mem_reset_req}, 32'h2);
    chk(mem_address == '0, {tag, "_addr"}, 32'(mem_address), 32'd0);
    chk(mem_writedata == 32'd0, {tag, "_wdata"}, mem_writedata, 32'd0);
    chk(mem_byteenable == 4'hF, {tag, "_be"}, 32'(mem_byteenable), 32'hF);
  endtask

  // Monitor: invariants every cycle, pops expected writes/done pulses when the DUT shows them
  initial begin
    wr_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk(s_ready == !done, "s_ready_vs_fin", 32'(s_ready), 32'(!done));
        chk(mem_clken == !busy, "clken_vs_busy", 32'(mem_clken), 32'(!busy));
        chk(mem_reset_req == busy, "reset_req_vs_busy", 32'(mem_reset_req), 32'(busy));
        chk(mem_chipselect == mem_write, "cs_vs_write", 32'(mem_chipselect), 32'(mem_write));
        chk(mem_byteenable == 4'hF, "byteenable", 32'(mem_byteenable), 32'hF);
        if (acc_q) chk(busy && !mem_clken, "busy_after_byte", 32'(busy), 32'd1);
        if (done_prev) chk(!busy, "busy_after_fin", 32'(busy), 32'd0);
        if (mem_write) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_write", 32'(mem_address), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk(mem_address == e.addr, "wr_addr", 32'(mem_address), 32'(e.addr));
            chk(mem_writedata == e.data, "wr_data", mem_writedata, e.data);
            chk(cyc == e.stamp, "wr_latency", 32'(cyc), 32'(e.stamp));
          end
          dut_ram[mem_address] = mem_writedata;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk(1'b0, "unexpected_done", 32'(cyc), 32'd0);
          end else begin
            d = done_q.pop_front();
            chk(cyc == d, "done_cycle", 32'(cyc), 32'(d));
          end
        end
        if (error) err_cnt++;
        done_prev = done;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  initial begin
    int st, e0, w;
    for (int i = 0; i < 512; i++) begin ref_ram[i] = 32'd0; dut_ram[i] = 32'd0; end
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back two-word frame at 0x010
    words.delete();
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    frame(32'h0010, 2, 8, 0);
    repeat (3) @(posedge clk); #1;

    // Address wrap 0x1FF -> 0x000; upper address bits ignored
    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    frame(32'h01FF, 2, 8, 1);
    words.delete();
    words.push_back($urandom);
    frame(32'hFE03, 1, 4, 0);
    repeat (3) @(posedge clk); #1;

    // Zero-length frame
    frame(32'h0005, 0, 0, 0);
    repeat (3) @(posedge clk); #1;

    // Timeout after two data bytes, then a normal frame
    e0 = err_cnt;
    words.delete();
    words.push_back(32'h11223344);
    frame(32'h0020, 1, 2, 0);
    repeat (TMO + 4) @(posedge clk);
    #1;
    chk(err_cnt == e0 + 1, "timeout_error_pulses", 32'(err_cnt - e0), 32'd1);
    chk(busy == 1'b0, "idle_after_timeout", 32'(busy), 32'd0);
    words.delete();
    words.push_back(32'hDDCCBBAA);
    frame(32'h0000, 1, 4, 0);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset mid-DATA after three bytes
    words.delete();
    words.push_back(32'h55667788);
    words.push_back(32'h99AABBCC);
    frame(32'h0040, 2, 3, 0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_vals("mid_frame_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    words.delete();
    words.push_back(32'hCAFEF00D);
    words.push_back(32'h0BADC0DE);
    frame(32'h0040, 2, 8, 0);

    // Random 16-word frame plus short random frames, gaps below the timeout
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back($urandom);
    frame(int'($urandom_range(16'hFFFF, 0)), 16, 64, 5);
    for (int f = 0; f < 4; f++) begin
      int len;
      len = $urandom_range(5, 0);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      frame(int'($urandom_range(16'hFFFF, 0)), len, 4 * len, 5);
    end

    w = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && w < 20) begin
      w++;
      @(posedge clk);
    end
    #1;
    chk(exp_q.size() == 0, "writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk(done_q.size() == 0, "done_outstanding", 32'(done_q.size()), 32'd0);
    chk(err_cnt == 1, "total_error_pulses", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 512; i++)
      chk(dut_ram[i] == ref_ram[i], "ram_contents", dut_ram[i], ref_ram[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/onchip_mem_stream_loader.md
Name: onchip_mem_stream_loader

Overview:
- Upstream write master for the 512x32 single-port on-chip program RAM.
- Accepts a framed byte stream (UART/JTAG boot path), assembles little-endian 32-bit words, and issues single-cycle full-word writes on the RAM's Avalon-style slave port.
- Holds the RAM's read clock-enable off and raises a CPU hold request while a frame is loading, so the processor never fetches half-loaded code.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width; the address wraps modulo 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 65535, maximum idle clocks between bytes inside a frame before the frame is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_ready  out  1  byte accepted when s_valid & s_ready at a clk edge
- mem_address  out  ADDR_WIDTH  RAM word address
- mem_byteenable  out  4  always 4'hF
- mem_chipselect  out  1  RAM select; equal to mem_write
- mem_write  out  1  one-cycle write strobe
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_reset_req  out  1  RAM reset request; equal to busy
- busy  out  1  frame in progress; also the CPU hold request
- done  out  1  one-cycle pulse on frame completion
- error  out  1  one-cycle pulse on frame abort (timeout)

Behaviour:
- Frame format (bytes): ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN*4 data bytes, least significant byte of each word first.
  - Start address = {ADDR_HI,ADDR_LO}[ADDR_WIDTH-1:0]; upper bits are ignored.
  - LEN is a 16-bit word count.
- States: H_ALO, H_AHI, H_LLO, H_LHI, DATA, FIN.
  - H_ALO -> H_AHI -> H_LLO -> H_LHI: each transition occurs on an accepted byte.
  - H_LHI -> DATA on an accepted byte when LEN != 0.
  - H_LHI -> FIN on an accepted byte when LEN == 0.
  - DATA stays in DATA until the LEN-th word's fourth byte is accepted, then goes to FIN.
  - FIN -> H_ALO unconditionally after one cycle.
- Output rules:
  - s_ready = 1 in every state except FIN.
  - busy = 1 in every state except H_ALO.
  - mem_clken = ~busy.
  - done = 1 exactly during FIN.
- Byte assembly: a 2-bit byte counter and a 24-bit shift register. When the fourth byte is accepted, the next cycle must show:
  - mem_write = mem_chipselect = 1;
  - mem_writedata = {b3,b2,b1,b0};
  - mem_address = current word address.
  - Write latency: exactly 1 clk after the fourth byte's handshake. The RAM has no waitrequest.
- The word address increments after each write and wraps from 2^ADDR_WIDTH-1 to 0; no error is raised on wrap.
- The remaining-word counter is 16 bits and decrements per write. LEN = 65535 is legal (the address wraps repeatedly).
- The next data byte may be accepted in the same cycle the preceding word's write is on the bus. Back-to-back bytes give one write every 4 clks.
- The final write and FIN occur in the same cycle, so done coincides with the last mem_write.
- Timeout: an idle counter runs in every state except H_ALO and FIN.
  - It resets to 0 on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: error pulses for 1 cycle, the state returns to H_ALO, and the byte counter clears.
  - Words already written stay in RAM; no write is issued for a partial word.
- Simultaneous events: if an accepted byte arrives in the same cycle the timeout count is reached, the byte wins and there is no abort.
- Reset values (asynchronous on reset_n low, taking effect mid-frame too):
  - state = H_ALO; all counters = 0.
  - s_ready = 1, mem_write = 0, mem_chipselect = 0, mem_address = 0, mem_writedata = 0, mem_byteenable = 4'hF.
  - mem_clken = 1, busy = 0, mem_reset_req = 0, done = 0, error = 0.
  - A write in flight is dropped.

Test Plan:
- Frame 10 00 02 00 | 78 56 34 12 | EF BE AD DE streamed back-to-back -> writes 0x12345678 @0x010, then 0xDEADBEEF @0x011 four clks later; done coincides with the second write; busy spans from the first byte to FIN.
- Header FF 01 02 00 (address 0x1FF), 2 words -> writes land at 0x1FF then 0x000; no error.
- Header 05 00 00 00 (LEN = 0) -> no mem_write; done pulses one clk after the fourth header byte; busy falls the following cycle.
- TIMEOUT_CYCLES = 8, s_valid dropped for 8 clks after 2 data bytes -> error pulses once; no write; the next frame 00 00 01 00 AA BB CC DD writes 0xDDCCBBAA @0x000.
- reset_n pulsed low mid-DATA after 3 bytes -> all outputs return to reset values immediately; no write is issued; a following frame loads normally from H_ALO.
- Random s_valid gaps (below the timeout) on a 16-word frame -> RAM contents match a reference model; mem_write never exceeds one per 4 accepted bytes; mem_clken = 0 throughout the frame.
